// File: rtl/alu_arbiter_if.sv
// Per-requester handshake bundle for alu_arbiter.
// The requester drives the request channel and the response ready; the
// arbiter drives request ready and response valid. Response payload is
// shared between requesters and lives on the arbiter's top-level ports.
`timescale 1ns/1ps
interface alu_arbiter_if #(
    parameter int DATA_W = 19,
    parameter int OP_W   = 5,
    parameter int TAG_W  = 4
) ();
    logic              req_valid;
    logic              req_ready;
    logic [OP_W-1:0]   req_op;
    logic [DATA_W-1:0] req_a;
    logic [DATA_W-1:0] req_b;
    logic [TAG_W-1:0]  req_tag;
    logic              rsp_valid;
    logic              rsp_ready;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        input  req_ready, rsp_valid
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
        output req_ready, rsp_valid
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared combinational ALU.
// One operation in flight: the winner's operands/opcode are registered onto
// the ALU inputs, held for a per-opcode number of cycles, then the ALU result
// is captured and returned to the owning port with its tag.
`timescale 1ns/1ps
module alu_arbiter #(
    parameter int DATA_W  = 19,
    parameter int OP_W    = 5,
    parameter int TAG_W   = 4,
    parameter int MUL_CYC = 2,
    parameter int DIV_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      p0,
    alu_arbiter_if.slave      p1,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_out,
    output logic              busy
);
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = 4;

    // alu_ctrl encoding shared with the ALU; anything else is illegal
    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOT   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MUL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_ENCRY = OP_W'(8);
    localparam logic [OP_W-1:0] OP_DECRY = OP_W'(9);
    localparam logic [OP_W-1:0] OP_IMMED = OP_W'(10);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [TAG_W-1:0]  tag;
    } req_t;

    req_t [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] req_valid;
    logic [NUM_PORTS-1:0] req_ready;
    logic [NUM_PORTS-1:0] rsp_ready;
    logic [NUM_PORTS-1:0] rsp_valid_q;
    logic [NUM_PORTS-1:0] grant;

    state_t           state;
    logic             last;      // port that won the most recent accept
    logic             owner;     // port that owns the op in flight
    logic [CNT_W-1:0] cnt;       // EXEC cycles remaining

    req_t             sel;
    logic             win;
    logic             accept;
    logic             op_legal;
    logic [CNT_W-1:0] op_lat;
    logic             div_zero;

    assign req[0]       = {p0.req_op, p0.req_a, p0.req_b, p0.req_tag};
    assign req[1]       = {p1.req_op, p1.req_a, p1.req_b, p1.req_tag};
    assign req_valid    = {p1.req_valid, p0.req_valid};
    assign rsp_ready    = {p1.rsp_ready, p0.rsp_ready};
    assign p0.req_ready = req_ready[0];
    assign p1.req_ready = req_ready[1];
    assign p0.rsp_valid = rsp_valid_q[0];
    assign p1.rsp_valid = rsp_valid_q[1];

    // Round-robin grant: on a tie the port after `last` wins
    always_comb begin
        grant = '0;
        if (req_valid[0] && (!req_valid[1] || last))
            grant[0] = 1'b1;
        else if (req_valid[1])
            grant[1] = 1'b1;
    end

    assign win       = grant[1];
    assign sel       = req[win];
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = |req_ready;

    // Opcode decode: legality and EXEC length for the granted request
    always_comb begin
        op_legal = 1'b1;
        op_lat   = CNT_W'(1);
        case (sel.op)
            OP_MUL: op_lat = CNT_W'(MUL_CYC);
            OP_DIV: op_lat = CNT_W'(DIV_CYC);
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_ENCRY, OP_DECRY, OP_IMMED: op_lat = CNT_W'(1);
            default: op_legal = 1'b0;
        endcase
    end

    assign div_zero = (sel.op == OP_DIV) && (sel.b == '0);

    // Control FSM with registered ALU inputs and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            cnt         <= '0;
            rsp_valid_q <= '0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
            rsp_err     <= 1'b0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_ctrl    <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_in1  <= sel.a;
                        alu_in2  <= sel.b;
                        alu_ctrl <= sel.op;
                        rsp_tag  <= sel.tag;
                        owner    <= win;
                        last     <= win;
                        busy     <= 1'b1;
                        if (!op_legal) begin
                            // unknown opcode: answer immediately, no ALU cycle
                            rsp_data    <= '0;
                            rsp_err     <= 1'b1;
                            rsp_valid_q <= grant;
                            state       <= RESP;
                        end else if (div_zero) begin
                            // divide by zero saturates to all-ones
                            rsp_data    <= '1;
                            rsp_err     <= 1'b1;
                            rsp_valid_q <= grant;
                            state       <= RESP;
                        end else begin
                            cnt   <= op_lat;
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_data    <= alu_out;
                        rsp_err     <= 1'b0;
                        rsp_valid_q <= NUM_PORTS'(1) << owner;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (|(rsp_valid_q & rsp_ready)) begin
                        rsp_valid_q <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Never grant both requesters in the same cycle
    a_one_ready: assert property (@(posedge clk) disable iff (rst)
        !(req_ready[0] && req_ready[1]));

    // Response goes to the owner only
    a_one_rsp: assert property (@(posedge clk) disable iff (rst)
        !(rsp_valid_q[0] && rsp_valid_q[1]));
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: drivers push expected responses at
// accept time, a monitor pops and compares whenever a response is presented.
`timescale 1ns/1ps
module tb_alu_arbiter;
    localparam int DW = 19;
    localparam int OW = 5;
    localparam int TW = 4;
    localparam int MUL_CYC = 2;
    localparam int DIV_CYC = 4;

    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,   OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3,  OP_XOR = 5'd4,   OP_NOT = 5'd5;
    localparam logic [4:0] OP_MUL = 5'd6,  OP_DIV = 5'd7,   OP_ENC = 5'd8;
    localparam logic [4:0] OP_DEC = 5'd9,  OP_IMM = 5'd10;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic [TW-1:0] tag;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int hs_edge = 0;
    exp_t q[$];
    int acc_log[$];
    int mode[2] = '{0, 0};  // rsp_ready: 0 high, 1 random, 2 low

    logic [1:0]         t_valid = '0;
    logic [1:0][OW-1:0] t_op    = '0;
    logic [1:0][DW-1:0] t_a     = '0;
    logic [1:0][DW-1:0] t_b     = '0;
    logic [1:0][TW-1:0] t_tag   = '0;
    logic [1:0]         t_rrdy  = '0;

    alu_arbiter_if #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) p0 ();
    alu_arbiter_if #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW)) p1 ();

    logic [DW-1:0] rsp_data, alu_in1, alu_in2, alu_out;
    logic [TW-1:0] rsp_tag;
    logic [OW-1:0] alu_ctrl;
    logic          rsp_err, busy;
    logic [1:0]    rdy, vld, rv;

    assign p0.req_valid = t_valid[0];  assign p1.req_valid = t_valid[1];
    assign p0.req_op    = t_op[0];     assign p1.req_op    = t_op[1];
    assign p0.req_a     = t_a[0];      assign p1.req_a     = t_a[1];
    assign p0.req_b     = t_b[0];      assign p1.req_b     = t_b[1];
    assign p0.req_tag   = t_tag[0];    assign p1.req_tag   = t_tag[1];
    assign p0.rsp_ready = t_rrdy[0];   assign p1.rsp_ready = t_rrdy[1];
    assign rdy = {p1.req_ready, p0.req_ready};
    assign vld = t_valid;
    assign rv  = {p1.rsp_valid, p0.rsp_valid};

    alu_arbiter #(.DATA_W(DW), .OP_W(OW), .TAG_W(TW),
                  .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .rst(rst), .p0(p0), .p1(p1),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .busy(busy));

    // Behavioural stand-in for the shared combinational ALU
    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op, input logic [DW-1:0] a, b);
        logic [DW-1:0] x;
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_NOT: return ~a;
            OP_MUL: return a * b;
            OP_DIV: return (b == 0) ? '0 : a / b;
            OP_ENC: return {a[DW-2:0], a[DW-1]} ^ b;
            OP_DEC: begin x = a ^ b; return {x[0], x[DW-1:1]}; end
            OP_IMM: return b;
            default: return 19'h5A5A5;
        endcase
    endfunction

    assign alu_out = alu_f(alu_ctrl, alu_in1, alu_in2);

    // Reference rules: illegal op and zero divide answer at once with err
    function automatic void model(input logic [OW-1:0] op, input logic [DW-1:0] a, b,
                                  output logic [DW-1:0] d, output logic e, output int l);
        if (op > OP_IMM) begin d = '0; e = 1'b1; l = 0; end
        else if (op == OP_DIV && b == 0) begin d = 19'h7FFFF; e = 1'b1; l = 0; end
        else begin
            d = alu_f(op, a, b); e = 1'b0;
            l = (op == OP_MUL) ? MUL_CYC : (op == OP_DIV) ? DIV_CYC : 1;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Present a request from a negedge, hold until accepted, push expectation
    task automatic drive(input int p, input logic [OW-1:0] op, input logic [DW-1:0] a, b,
                         input logic [TW-1:0] tag, input bit use_exp,
                         input logic [DW-1:0] ed, input logic ee, input int el, output int acc);
        exp_t e;
        int n = 0;
        t_op[p] = op; t_a[p] = a; t_b[p] = b; t_tag[p] = tag; t_valid[p] = 1'b1;
        #1;
        while (!rdy[p] && n < 300) begin @(negedge clk); #1; n++; end
        if (!rdy[p]) begin
            tests++; fails++;
            $display("FAIL req_timeout: port %0d never accepted, expected accept within 300 cycles", p);
            t_valid[p] = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            @(negedge clk);
            t_valid[p] = 1'b0;
            acc = cyc;
            e.port = p; e.tag = tag; e.acc = cyc;
            if (use_exp) begin e.data = ed; e.err = ee; e.lat = el; end
            else model(op, a, b, e.data, e.err, e.lat);
            q.push_back(e);
            acc_log.push_back(p);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
    endtask

    task automatic rand_port(input int p, input int n);
        logic [OW-1:0] op;
        logic [DW-1:0] a, b;
        int acc;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = ($urandom_range(0, 12) == 0) ? OW'($urandom_range(11, 31)) : OW'($urandom_range(0, 10));
            a  = DW'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
            if (op == OP_DIV && $urandom_range(0, 1) == 1) b = DW'($urandom_range(1, 40));
            drive(p, op, a, b, TW'($urandom), 1'b0, '0, 1'b0, 0, acc);
        end
    endtask

    task automatic chk_all_zero(input string tagname);
        chk({tagname, "_rsp_valid"}, rv, 0);
        chk({tagname, "_rsp_data"}, rsp_data, 0);
        chk({tagname, "_rsp_tag"}, rsp_tag, 0);
        chk({tagname, "_rsp_err"}, rsp_err, 0);
        chk({tagname, "_alu_in1"}, alu_in1, 0);
        chk({tagname, "_alu_in2"}, alu_in2, 0);
        chk({tagname, "_alu_ctrl"}, alu_ctrl, 0);
        chk({tagname, "_busy"}, busy, 0);
    endtask

    // rsp_ready generator
    initial forever begin
        @(negedge clk);
        for (int p = 0; p < 2; p++)
            t_rrdy[p] = (mode[p] == 0) ? 1'b1 : (mode[p] == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Monitor: arbitration model plus response scoreboard
    initial begin : mon
        exp_t e;
        bit   in_resp = 0;
        int   last_m  = 1;
        int   w;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                q.delete(); in_resp = 0; last_m = 1;
            end else begin
                chk("busy", busy, q.size() != 0);
                if (q.size() != 0) begin
                    if (vld != 0) chk("ready_while_busy", rdy, 0);
                end else if (vld != 0) begin
                    w = (vld == 2'b11) ? (last_m == 1 ? 0 : 1) : (vld[1] ? 1 : 0);
                    chk("grant", rdy, 2'b01 << w);
                    last_m = w;
                end
                if (q.size() == 0) begin
                    if (rv != 0) chk("unexpected_rsp", rv, 0);
                end else begin
                    e = q[0];
                    if (rv != 0) begin
                        if (!in_resp) begin chk("latency", cyc - e.acc, e.lat); in_resp = 1; end
                        chk("rsp_route", rv, 2'b01 << e.port);
                        chk("rsp_data", rsp_data, e.data);
                        chk("rsp_tag", rsp_tag, e.tag);
                        chk("rsp_err", rsp_err, e.err);
                        if (t_rrdy[e.port]) begin
                            void'(q.pop_front()); in_resp = 0; hs_edge = cyc + 1;
                        end
                    end else if (in_resp) begin
                        chk("rsp_dropped", rv, 2'b01 << e.port);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc, acc_b, n;
        int accs[4];
        logic [OW-1:0] sops[4] = '{OP_SUB, OP_AND, OP_OR, OP_XOR};
        logic [DW-1:0] sexp[4] = '{19'h04B4B, 19'h10000, 19'h1FFFF, 19'h0FFFF};

        // reset: ready forced low, outputs cleared
        repeat (2) @(negedge clk);
        t_valid[0] = 1'b1;
        #1 chk("ready_in_reset", rdy, 0);
        t_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #3 chk_all_zero("reset");
        @(negedge clk);

        // single ADD on port 0
        drive(0, OP_ADD, 19'h1A5A5, 19'h15A5A, 4'd3, 1'b1, 19'h2FFFF, 1'b0, 1, acc);
        drain();

        // port 1 back-to-back, spacing 3 cycles
        for (int i = 0; i < 4; i++)
            drive(1, sops[i], 19'h1A5A5, 19'h15A5A, TW'(i + 1), 1'b1, sexp[i], 1'b0, 1, accs[i]);
        for (int i = 1; i < 4; i++) chk("accept_spacing", accs[i] - accs[i-1], 3);
        drain();

        // both ports continuously valid: alternate starting with port 0
        acc_log.delete();
        fork
            for (int i = 0; i < 4; i++) drive(0, OP_ADD, DW'($urandom), DW'($urandom), TW'(i), 1'b0, '0, 1'b0, 0, acc);
            for (int j = 0; j < 4; j++) drive(1, OP_XOR, DW'($urandom), DW'($urandom), TW'(8 + j), 1'b0, '0, 1'b0, 0, acc_b);
        join
        chk("alt_count", acc_log.size(), 8);
        for (int i = 0; i < 8 && i < acc_log.size(); i++) chk("alt_order", acc_log[i], i % 2);
        drain();

        // multi-cycle and zero-divide
        drive(0, OP_MUL, 19'h00003, 19'h00005, 4'd5, 1'b1, 19'h0000F, 1'b0, 2, acc);
        drain();
        drive(0, OP_DIV, 19'h00064, 19'h00005, 4'd6, 1'b1, 19'h00014, 1'b0, 4, acc);
        drain();
        drive(0, OP_DIV, 19'h00064, 19'h00000, 4'd7, 1'b1, 19'h7FFFF, 1'b1, 0, acc);
        drain();
        drive(0, 5'd20, 19'h00011, 19'h00022, 4'd8, 1'b1, 19'h00000, 1'b1, 0, acc);
        drain();

        // response stall while port 1 waits
        mode[0] = 2;
        drive(0, OP_ADD, 19'h00100, 19'h00023, 4'd9, 1'b1, 19'h00123, 1'b0, 1, acc);
        fork
            drive(1, OP_OR, 19'h00F00, 19'h0000F, 4'd10, 1'b1, 19'h00F0F, 1'b0, 1, acc_b);
            begin
                n = 0;
                while (!p0.rsp_valid && n < 20) begin @(negedge clk); n++; end
                repeat (5) @(negedge clk);
                mode[0] = 0;
            end
        join
        chk("stall_then_accept", acc_b, hs_edge + 1);
        drain();

        // reset mid-EXEC of DIV drops the op
        drive(0, OP_DIV, 19'h00064, 19'h00005, 4'd11, 1'b1, 19'h00014, 1'b0, 4, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3 chk_all_zero("mid_reset");
        @(negedge clk);
        drive(1, OP_SUB, 19'h00050, 19'h00010, 4'd12, 1'b1, 19'h00040, 1'b0, 1, acc);
        drain();

        // randomized traffic with random response backpressure
        mode[0] = 1; mode[1] = 1;
        @(negedge clk);
        fork
            rand_port(0, 40);
            rand_port(1, 40);
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
